cdma_img_fifo_arb: RTL and testbench
====================================

Name: cdma_img_fifo_arb

Overview:
- Two-source arbiter and credit manager for the shared 128-entry image-path FIFO.
- Merges two pixel-packer streams into the single FIFO write port using round-robin arbitration.
- Tags each entry with its source ID and caps each source's FIFO occupancy at a quota.
- Monitors the FIFO read handshake to return credits, and provides a flush/drain sequence for layer boundaries.

Parameters:
- DW, 10: payload width per source. FIFO entry width is DW+1, with the MSB being the source tag.
- DEPTH, 128: shared FIFO depth.
- CW, 8: occupancy counter width. Must satisfy 2^CW > DEPTH.
- QUOTA0, 64: maximum outstanding entries for source 0 (range 1..DEPTH).
- QUOTA1, 64: maximum outstanding entries for source 1 (range 1..DEPTH).

Ports:
- clk  in  1  clock
- reset_  in  1  reset, asynchronous, active-low
- src0_req  in  1  source 0 valid
- src0_ready  out  1  source 0 accepted this cycle
- src0_data  in  DW  source 0 payload
- src1_req  in  1  source 1 valid
- src1_ready  out  1  source 1 accepted this cycle
- src1_data  in  DW  source 1 payload
- fifo_wr_req  out  1  FIFO write valid (registered)
- fifo_wr_ready  in  1  FIFO write ready
- fifo_wr_data  out  DW+1  {tag, payload} (registered)
- fifo_rd_req  in  1  FIFO read valid (monitored only)
- fifo_rd_ready  in  1  consumer ready (monitored only)
- fifo_rd_data  in  DW+1  FIFO read data; only the tag bit is used
- flush_req  in  1  level request: stop granting and drain
- flush_done  out  1  one-cycle pulse when drain completes
- busy  out  1  any credit outstanding or output stage full

Behaviour:
- Reset values:
  - src*_ready=0, fifo_wr_req=0, fifo_wr_data=0, flush_done=0, busy=0.
  - Counters cnt0=cnt1=0; RR pointer favours src0; FSM in RUN.
- Output stage:
  - A single register slot. It is free when !fifo_wr_req, or when fifo_wr_req && fifo_wr_ready.
  - Latency from source acceptance to fifo_wr_req is 1 cycle.
- Eligibility:
  - Source i is eligible when srci_req && cnt_i < QUOTAi && slot free && state==RUN.
- Grant rules:
  - At most one grant per cycle; srci_ready=1 only for the granted source. srci_ready is combinational.
  - Round-robin: if both sources are eligible, the source not granted last time wins.
  - The pointer updates only on a grant. A single eligible source wins regardless of the pointer.
- On grant:
  - Slot loads {i, srci_data}.
  - cnt_i increments in the same cycle. This reserves the credit, so slot entries count against quota.
- Credit return:
  - When fifo_rd_req && fifo_rd_ready, cnt[fifo_rd_data[DW]] decrements.
  - If the same counter sees a grant and a return in the same cycle, it is unchanged.
  - Increments and decrements on different counters apply independently.
- Counter safety: counters never wrap.
  - A decrement at 0 is an illegal stimulus; the assertion flags it and the counter holds 0.
  - cnt_i never exceeds QUOTAi.
- FSM:
  - RUN: flush_req=1 → DRAIN.
  - DRAIN:
    - No grants are issued; the output slot still completes to the FIFO.
    - When cnt0==0 && cnt1==0 && !fifo_wr_req → DONE.
  - DONE:
    - flush_done=1 for exactly the entry cycle.
    - Stays in DONE (no grants) until flush_req=0 → RUN.
    - The RR pointer is reset to favour src0 on the DONE→RUN transition.
- Flush deasserted in DRAIN: return to RUN immediately, with no flush_done pulse.
- busy = (cnt0!=0) || (cnt1!=0) || fifo_wr_req.
- Reset mid-operation: all state clears asynchronously. The FIFO is reset by the same reset_, so counters stay consistent with it.
- Invariant: cnt0+cnt1 <= DEPTH. It holds because QUOTA0+QUOTA1 <= DEPTH is required; a parameter check fails elaboration otherwise.

Optional Feature:
- Macro: CDMA_IMG_FIFO_ARB_PERF_EN.
- When defined, the following are added:
  - Output ports perf_stall0 and perf_stall1, each 32 bits, saturating.
  - perf_stall_i increments each cycle that srci_req=1 && srci_ready=0 while in RUN.
  - Both counters clear on reset and on the flush_done pulse.
- When undefined, the ports and logic are absent and the behaviour is otherwise identical.

Decomposition:
- Shared package cdma_img_arb_pkg:
  - FSM state enum (RUN, DRAIN, DONE).
  - Tag constants SRC0=1'b0, SRC1=1'b1.
  - Default DEPTH/QUOTA constants.
  - Entry typedef {tag, payload}.
- One natural sub-module, cdma_img_credit_cnt: a per-source up/down saturating counter with an at-quota compare. It is instantiated twice.

Test Plan:
- Only src0 streams 100 words, consumer stalled, QUOTA0=64 → exactly 64 grants, src0_ready then 0, cnt0=64. Release the consumer → remaining 36 are accepted.
- Both sources requesting continuously, consumer always ready → grants alternate 0,1,0,1…, and tags in fifo_wr_data alternate to match.
- fifo_wr_ready held 0 for 10 cycles with the slot full → no new grants, data stable. The transfer completes on the first ready cycle and a new grant follows in the same cycle.
- Same-cycle grant to src1 and pop with tag 1 at cnt1=5 → cnt1 stays 5. Same-cycle grant to src0 and pop with tag 1 → cnt0+1 and cnt1-1.
- 20 entries outstanding, then flush_req=1 → zero grants while in DRAIN. flush_done pulses 1 cycle after the 20th pop with the output slot empty. Deassert flush_req → grants resume with src0 first.
- Assert reset_ low mid-stream with counters at 30/12 → all outputs and counters are 0 immediately. With CDMA_IMG_FIFO_ARB_PERF_EN, perf_stall counters read 0.

Source files
------------

// File: rtl/cdma_img_arb_pkg.sv
// -----------------------------------------------------------------------------
// cdma_img_arb_pkg
// Shared definitions for the image-path FIFO arbiter:
//   - arb_state_e : arbiter FSM state (RUN / DRAIN / DONE)
//   - SRC0 / SRC1 : source tag values carried in the FIFO entry MSB
//   - default depth / quota / payload width constants
//   - img_entry_t : {tag, payload} layout of one FIFO entry (default width)
// -----------------------------------------------------------------------------
package cdma_img_arb_pkg;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StDrain = 2'd1,
        StDone  = 2'd2
    } arb_state_e;

    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;

    localparam int unsigned DefaultDw    = 10;
    localparam int unsigned DefaultDepth = 128;
    localparam int unsigned DefaultCw    = 8;
    localparam int unsigned DefaultQuota = 64;

    typedef struct packed {
        logic                 tag;
        logic [DefaultDw-1:0] payload;
    } img_entry_t;

endpackage

// File: rtl/cdma_img_credit_cnt.sv
// -----------------------------------------------------------------------------
// cdma_img_credit_cnt
// Per-source outstanding-entry counter. Increments on a grant, decrements on a
// credit return, holds when both happen together. Never wraps: it stops at
// QUOTA going up and at zero going down.
//
// Ports:
//   clk      in   clock
//   reset_   in   asynchronous active-low reset
//   inc      in   grant to this source this cycle
//   dec      in   credit returned to this source this cycle
//   cnt      out  current outstanding count
//   at_quota out  cnt has reached QUOTA (source must not be granted)
//   nonzero  out  at least one credit outstanding
// -----------------------------------------------------------------------------
module cdma_img_credit_cnt
    import cdma_img_arb_pkg::*;
#(
    parameter int unsigned CW    = DefaultCw,
    parameter int unsigned QUOTA = DefaultQuota
) (
    input  logic          clk,
    input  logic          reset_,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] cnt,
    output logic          at_quota,
    output logic          nonzero
);

    localparam logic [CW-1:0] QuotaVal = CW'(QUOTA);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({inc, dec})
            2'b10: begin
                if (cnt_q < QuotaVal) cnt_d = cnt_q + 1'b1;
            end
            2'b01: begin
                // A return at zero is illegal; hold rather than wrap.
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            end
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt      = cnt_q;
    assign at_quota = (cnt_q >= QuotaVal);
    assign nonzero  = (cnt_q != '0);

    underflow_chk : assert property (@(posedge clk) disable iff (!reset_)
                                     !(dec && !inc && (cnt_q == '0)))
        else $error("cdma_img_credit_cnt: credit returned with none outstanding");

endmodule

// File: rtl/cdma_img_fifo_arb.sv
// -----------------------------------------------------------------------------
// cdma_img_fifo_arb
// Round-robin arbiter and credit manager in front of the shared image-path
// FIFO. Two pixel-packer sources compete for a single registered output slot;
// each accepted word is tagged with its source ID and reserves one credit
// until the consumer pops it from the FIFO. A flush request stops granting,
// waits for every credit to come back and the slot to empty, then pulses
// flush_done.
//
// Optional feature (macro CDMA_IMG_FIFO_ARB_PERF_EN): adds saturating 32-bit
// stall counters perf_stall0/perf_stall1.
//
// Ports:
//   clk, reset_              clock, asynchronous active-low reset
//   src0_req/ready/data      source 0 handshake (ready is combinational grant)
//   src1_req/ready/data      source 1 handshake
//   fifo_wr_req/ready/data   FIFO write port, {tag, payload}, registered
//   fifo_rd_req/ready/data   FIFO read handshake, monitored for credit return
//   flush_req                level request to stop granting and drain
//   flush_done               one-cycle pulse when the drain completes
//   perf_stall0/1            (optional) cycles a source waited while in RUN
//   busy                     credits outstanding or output slot full
// -----------------------------------------------------------------------------
module cdma_img_fifo_arb
    import cdma_img_arb_pkg::*;
#(
    parameter int unsigned DW     = DefaultDw,
    parameter int unsigned DEPTH  = DefaultDepth,
    parameter int unsigned CW     = DefaultCw,
    parameter int unsigned QUOTA0 = DefaultQuota,
    parameter int unsigned QUOTA1 = DefaultQuota
) (
    input  logic          clk,
    input  logic          reset_,
    input  logic          src0_req,
    output logic          src0_ready,
    input  logic [DW-1:0] src0_data,
    input  logic          src1_req,
    output logic          src1_ready,
    input  logic [DW-1:0] src1_data,
    output logic          fifo_wr_req,
    input  logic          fifo_wr_ready,
    output logic [DW:0]   fifo_wr_data,
    input  logic          fifo_rd_req,
    input  logic          fifo_rd_ready,
    input  logic [DW:0]   fifo_rd_data,
    input  logic          flush_req,
    output logic          flush_done,
`ifdef CDMA_IMG_FIFO_ARB_PERF_EN
    output logic [31:0]   perf_stall0,
    output logic [31:0]   perf_stall1,
`endif
    output logic          busy
);

    // Quotas must fit the shared FIFO together, and counters must hold DEPTH.
    if ((QUOTA0 < 1) || (QUOTA1 < 1) || (QUOTA0 > DEPTH) || (QUOTA1 > DEPTH) ||
        ((QUOTA0 + QUOTA1) > DEPTH) || ((64'd1 << CW) <= 64'(DEPTH))) begin : g_param_err
        $error("cdma_img_fifo_arb: illegal DEPTH/CW/QUOTA parameter set");
    end

    arb_state_e    state_q;
    logic          prio_q;        // 0: src0 wins a tie, 1: src1 wins a tie
    logic          wr_req_q;
    logic [DW:0]   wr_data_q;
    logic          flush_done_q;

    logic [CW-1:0] cnt0, cnt1;
    logic          full0, full1;
    logic          nz0, nz1;

    logic          slot_free;
    logic          run;
    logic          elig0, elig1;
    logic          grant0, grant1;
    logic          rd_fire;
    logic          dec0, dec1;

    // Only the tag bit of the read data matters for credit return.
    logic          unused_rd_payload;
    assign unused_rd_payload = ^fifo_rd_data[DW-1:0];

    // -------------------------------------------------------------------------
    // Eligibility and round-robin grant
    // -------------------------------------------------------------------------
    assign slot_free = !wr_req_q || fifo_wr_ready;
    // Gate with reset_ so no ready is shown while the block is held in reset.
    assign run       = (state_q == StRun) && reset_;

    assign elig0  = src0_req && !full0 && slot_free && run;
    assign elig1  = src1_req && !full1 && slot_free && run;

    assign grant0 = elig0 && (!elig1 || !prio_q);
    assign grant1 = elig1 && (!elig0 ||  prio_q);

    assign src0_ready = grant0;
    assign src1_ready = grant1;

    // -------------------------------------------------------------------------
    // Credit counters
    // -------------------------------------------------------------------------
    assign rd_fire = fifo_rd_req && fifo_rd_ready;
    assign dec0    = rd_fire && (fifo_rd_data[DW] == SRC0);
    assign dec1    = rd_fire && (fifo_rd_data[DW] == SRC1);

    cdma_img_credit_cnt #(
        .CW    (CW),
        .QUOTA (QUOTA0)
    ) u_cnt0 (
        .clk      (clk),
        .reset_   (reset_),
        .inc      (grant0),
        .dec      (dec0),
        .cnt      (cnt0),
        .at_quota (full0),
        .nonzero  (nz0)
    );

    cdma_img_credit_cnt #(
        .CW    (CW),
        .QUOTA (QUOTA1)
    ) u_cnt1 (
        .clk      (clk),
        .reset_   (reset_),
        .inc      (grant1),
        .dec      (dec1),
        .cnt      (cnt1),
        .at_quota (full1),
        .nonzero  (nz1)
    );

    // -------------------------------------------------------------------------
    // Output slot: loads on grant, empties when the FIFO takes it
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wr_req_q  <= 1'b0;
            wr_data_q <= '0;
        end else if (grant0 || grant1) begin
            wr_req_q  <= 1'b1;
            wr_data_q <= grant1 ? {SRC1, src1_data} : {SRC0, src0_data};
        end else if (fifo_wr_ready) begin
            wr_req_q  <= 1'b0;
        end
    end

    assign fifo_wr_req  = wr_req_q;
    assign fifo_wr_data = wr_data_q;

    // -------------------------------------------------------------------------
    // Flush FSM and round-robin pointer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q      <= StRun;
            prio_q       <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            flush_done_q <= 1'b0;
            unique case (state_q)
                StRun: begin
                    if (grant0)      prio_q <= 1'b1;
                    else if (grant1) prio_q <= 1'b0;
                    if (flush_req) state_q <= StDrain;
                end
                StDrain: begin
                    // Dropping the request aborts the drain without a pulse.
                    if (!flush_req) begin
                        state_q <= StRun;
                    end else if (!nz0 && !nz1 && !wr_req_q) begin
                        state_q      <= StDone;
                        flush_done_q <= 1'b1;
                    end
                end
                StDone: begin
                    if (!flush_req) begin
                        state_q <= StRun;
                        prio_q  <= 1'b0;
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

    assign flush_done = flush_done_q;
    assign busy       = nz0 || nz1 || wr_req_q;

`ifdef CDMA_IMG_FIFO_ARB_PERF_EN
    // -------------------------------------------------------------------------
    // Stall counters: cycles a requesting source was refused while in RUN
    // -------------------------------------------------------------------------
    logic [31:0] stall0_q, stall1_q;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            stall0_q <= '0;
            stall1_q <= '0;
        end else if (flush_done_q) begin
            stall0_q <= '0;
            stall1_q <= '0;
        end else if (state_q == StRun) begin
            if (src0_req && !grant0 && (stall0_q != '1)) stall0_q <= stall0_q + 1'b1;
            if (src1_req && !grant1 && (stall1_q != '1)) stall1_q <= stall1_q + 1'b1;
        end
    end

    assign perf_stall0 = stall0_q;
    assign perf_stall1 = stall1_q;
`endif

endmodule

// File: tb/tb_cdma_img_fifo_arb.sv
// -----------------------------------------------------------------------------
// tb_cdma_img_fifo_arb
// Self-checking bench for cdma_img_fifo_arb. A behavioural model (credit
// totals, a queue standing in for the FIFO, a one-entry slot and a tie
// preference) predicts grants and outputs each cycle; directed phases and a
// randomized soak drive the block.
// -----------------------------------------------------------------------------
module tb_cdma_img_fifo_arb;

    localparam int DW = 10;
    localparam int Q0 = 64;
    localparam int Q1 = 64;

    localparam int MRun   = 0;
    localparam int MDrain = 1;
    localparam int MDone  = 2;

    logic          clk = 1'b0;
    logic          reset_ = 1'b0;
    logic          src0_req = 1'b0, src1_req = 1'b0;
    logic [DW-1:0] src0_data = '0, src1_data = '0;
    logic          src0_ready, src1_ready;
    logic          fifo_wr_req;
    logic          fifo_wr_ready = 1'b1;
    logic [DW:0]   fifo_wr_data;
    logic          fifo_rd_req = 1'b0, fifo_rd_ready = 1'b0;
    logic [DW:0]   fifo_rd_data = '0;
    logic          flush_req = 1'b0;
    logic          flush_done;
    logic          busy;
`ifdef CDMA_IMG_FIFO_ARB_PERF_EN
    logic [31:0]   perf_stall0, perf_stall1;
`endif

    cdma_img_fifo_arb dut (
        .clk           (clk),
        .reset_        (reset_),
        .src0_req      (src0_req),
        .src0_ready    (src0_ready),
        .src0_data     (src0_data),
        .src1_req      (src1_req),
        .src1_ready    (src1_ready),
        .src1_data     (src1_data),
        .fifo_wr_req   (fifo_wr_req),
        .fifo_wr_ready (fifo_wr_ready),
        .fifo_wr_data  (fifo_wr_data),
        .fifo_rd_req   (fifo_rd_req),
        .fifo_rd_ready (fifo_rd_ready),
        .fifo_rd_data  (fifo_rd_data),
        .flush_req     (flush_req),
        .flush_done    (flush_done),
`ifdef CDMA_IMG_FIFO_ARB_PERF_EN
        .perf_stall0   (perf_stall0),
        .perf_stall1   (perf_stall1),
`endif
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    int          m_out [2];
    bit          m_slot_v;
    logic [DW:0] m_slot;
    bit          m_prio;
    int          m_st;
    bit          m_done;
    longint      m_perf [2];
    logic [DW:0] fq [$];

    bit cons_rdy = 1'b0;
    int obs_g;             // grant seen on the DUT this cycle: 0, 1 or -1
    int dut_grants [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_out[0] = 0; m_out[1] = 0;
        m_slot_v = 0; m_slot = '0;
        m_prio = 0; m_st = MRun; m_done = 0;
        m_perf[0] = 0; m_perf[1] = 0;
        fq.delete();
    endtask

    task automatic chk_reset_state(input string tag);
        check({tag, "_src0_ready"}, src0_ready, 0);
        check({tag, "_src1_ready"}, src1_ready, 0);
        check({tag, "_wr_req"}, fifo_wr_req, 0);
        check({tag, "_wr_data"}, fifo_wr_data, 0);
        check({tag, "_flush_done"}, flush_done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_cnt0"}, dut.cnt0, 0);
        check({tag, "_cnt1"}, dut.cnt1, 0);
`ifdef CDMA_IMG_FIFO_ARB_PERF_EN
        check({tag, "_perf0"}, perf_stall0, 0);
        check({tag, "_perf1"}, perf_stall1, 0);
`endif
    endtask

    // One clock cycle. Entered at a falling edge with source/flush inputs set.
    task automatic step();
        bit   sf, e0, e1, g0, g1, pre_idle, done_now;
        int   tag;
        fifo_rd_req   = (fq.size() != 0);
        fifo_rd_data  = fifo_rd_req ? fq[0] : '0;
        fifo_rd_ready = cons_rdy;
        #1;
        sf = !m_slot_v || fifo_wr_ready;
        e0 = src0_req && (m_out[0] < Q0) && sf && (m_st == MRun);
        e1 = src1_req && (m_out[1] < Q1) && sf && (m_st == MRun);
        g0 = e0 && (!e1 || !m_prio);
        g1 = e1 && (!e0 ||  m_prio);
        check("src0_ready", src0_ready, g0);
        check("src1_ready", src1_ready, g1);
        obs_g = src0_ready ? 0 : (src1_ready ? 1 : -1);
        if (obs_g >= 0) dut_grants[obs_g]++;

        @(posedge clk);
        pre_idle = (m_out[0] == 0) && (m_out[1] == 0) && !m_slot_v;
        if (m_done) begin
            m_perf[0] = 0; m_perf[1] = 0;
        end else if (m_st == MRun) begin
            if (src0_req && !g0) m_perf[0]++;
            if (src1_req && !g1) m_perf[1]++;
        end
        done_now = 0;
        case (m_st)
            MRun:   if (flush_req) m_st = MDrain;
            MDrain: begin
                if (!flush_req) m_st = MRun;
                else if (pre_idle) begin m_st = MDone; done_now = 1; end
            end
            default: if (!flush_req) begin m_st = MRun; m_prio = 0; end
        endcase
        m_done = done_now;
        if (fifo_rd_req && fifo_rd_ready) begin
            tag = int'(fq[0][DW]);
            void'(fq.pop_front());
            m_out[tag]--;
        end
        if (m_slot_v && fifo_wr_ready) begin
            fq.push_back(m_slot);
            m_slot_v = 0;
        end
        if (g0 || g1) begin
            m_slot_v = 1;
            m_slot   = g1 ? {1'b1, src1_data} : {1'b0, src0_data};
            m_out[g1 ? 1 : 0]++;
            m_prio   = g0;
        end

        #1;
        check("wr_req", fifo_wr_req, m_slot_v);
        if (m_slot_v) check("wr_data", fifo_wr_data, m_slot);
        check("busy", busy, (m_out[0] != 0) || (m_out[1] != 0) || m_slot_v);
        check("flush_done", flush_done, m_done);
        check("cnt0", dut.cnt0, m_out[0]);
        check("cnt1", dut.cnt1, m_out[1]);
`ifdef CDMA_IMG_FIFO_ARB_PERF_EN
        check("perf0", perf_stall0, m_perf[0]);
        check("perf1", perf_stall1, m_perf[1]);
`endif
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        src0_req = 0; src1_req = 0; fifo_wr_ready = 1; cons_rdy = 1; flush_req = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int prev_g, base, seen_done, drain_grants;

        model_reset();
        dut_grants[0] = 0; dut_grants[1] = 0;

        // Reset state, with requests pending to show ready stays low.
        src0_req = 1; src1_req = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_state("rst");
        reset_ = 1;
        src0_req = 0; src1_req = 0;

        // Only src0 streams 100 words into a stalled consumer.
        cons_rdy = 0; fifo_wr_ready = 1;
        for (int c = 0; c < 90; c++) begin
            src0_req = 1; src0_data = DW'($urandom); step();
        end
        check("s1_grants_at_quota", dut_grants[0], 64);
        check("s1_cnt0", dut.cnt0, 64);
        #1 check("s1_ready_low", src0_ready, 0);
        @(negedge clk);
        cons_rdy = 1;
        for (int c = 0; c < 300 && dut_grants[0] < 100; c++) begin
            src0_req = 1; src0_data = DW'($urandom); step();
        end
        check("s1_total_grants", dut_grants[0], 100);
        drain(150);

        // Both sources continuously requesting: grants alternate.
        prev_g = -1;
        for (int c = 0; c < 40; c++) begin
            src0_req = 1; src1_req = 1;
            src0_data = DW'($urandom); src1_data = DW'($urandom);
            step();
            check("s2_grant_each_cycle", obs_g >= 0, 1);
            if (prev_g >= 0 && obs_g >= 0) check("s2_alternate", obs_g, 1 - prev_g);
            prev_g = obs_g;
        end
        drain(150);

        // FIFO write back-pressure with the slot full.
        src0_req = 1; src1_req = 1; fifo_wr_ready = 0;
        src0_data = DW'($urandom); src1_data = DW'($urandom);
        step();
        for (int c = 0; c < 10; c++) begin
            src0_data = DW'($urandom); src1_data = DW'($urandom);
            step();
            check("s3_no_grant", obs_g, -1);
        end
        fifo_wr_ready = 1;
        step();
        check("s3_regrant_same_cycle", obs_g >= 0, 1);
        drain(150);

        // Same-cycle grant and credit return.
        cons_rdy = 0; base = dut_grants[1];
        for (int c = 0; c < 20 && dut_grants[1] < base + 5; c++) begin
            src1_req = 1; src1_data = DW'($urandom); step();
        end
        src1_req = 0; step(); step();
        check("s4_cnt1_setup", dut.cnt1, 5);
        src1_req = 1; src1_data = DW'($urandom); cons_rdy = 1;
        step();
        check("s4_grant1", obs_g, 1);
        check("s4_cnt1_same", dut.cnt1, 5);
        src1_req = 0; src0_req = 1; src0_data = DW'($urandom);
        step();
        check("s4_cnt0_inc", dut.cnt0, 1);
        check("s4_cnt1_dec", dut.cnt1, 4);
        drain(150);

        // Flush with 20 entries outstanding.
        cons_rdy = 0; base = dut_grants[0] + dut_grants[1];
        for (int c = 0; c < 40 && (dut_grants[0] + dut_grants[1]) < base + 20; c++) begin
            src0_req = 1; src1_req = 1;
            src0_data = DW'($urandom); src1_data = DW'($urandom);
            step();
        end
        src0_req = 0; src1_req = 0; step(); step();
        check("s5_outstanding", dut.cnt0 + dut.cnt1, 20);
        flush_req = 1; step();
        src0_req = 1; src1_req = 1; cons_rdy = 1;
        seen_done = 0; drain_grants = 0;
        for (int c = 0; c < 200 && !seen_done; c++) begin
            step();
            if (obs_g >= 0) drain_grants++;
            if (flush_done) seen_done = 1;
        end
        check("s5_drain_grants", drain_grants, 0);
        check("s5_flush_done_seen", seen_done, 1);
        step();
        check("s5_pulse_one_cycle", flush_done, 0);
        check("s5_done_no_grant", obs_g, -1);
        step();
        flush_req = 0; step();
        step();
        check("s5_resume_src0_first", obs_g, 0);
        drain(150);

        // Randomized soak.
        for (int c = 0; c < 3000; c++) begin
            src0_req = ($urandom_range(0, 9) < 7);
            src1_req = ($urandom_range(0, 9) < 6);
            src0_data = DW'($urandom); src1_data = DW'($urandom);
            fifo_wr_ready = ($urandom_range(0, 9) < 8);
            cons_rdy = ($urandom_range(0, 9) < ((c / 500) % 2 == 0 ? 3 : 8));
            if ($urandom_range(0, 99) == 0) flush_req = !flush_req;
            step();
        end
        drain(300);

        // Reset mid-stream with counters at 30/12.
        cons_rdy = 0; base = dut_grants[0];
        for (int c = 0; c < 60 && dut_grants[0] < base + 30; c++) begin
            src0_req = 1; src0_data = DW'($urandom); step();
        end
        src0_req = 0; base = dut_grants[1];
        for (int c = 0; c < 30 && dut_grants[1] < base + 12; c++) begin
            src1_req = 1; src1_data = DW'($urandom); step();
        end
        check("s7_cnt0_pre", dut.cnt0, 30);
        check("s7_cnt1_pre", dut.cnt1, 12);
        src0_req = 1; src1_req = 1;
        #2 reset_ = 0;
        #1 chk_reset_state("midrst");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_ = 1;
        for (int c = 0; c < 200; c++) begin
            src0_req = ($urandom_range(0, 1) == 1);
            src1_req = ($urandom_range(0, 1) == 1);
            src0_data = DW'($urandom); src1_data = DW'($urandom);
            fifo_wr_ready = ($urandom_range(0, 3) != 0);
            cons_rdy = ($urandom_range(0, 1) == 1);
            step();
        end
        drain(300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
